// File: rtl/xge_wb_pkg.sv
// Shared constants and types for the 10GE MAC Wishbone register block.
package xge_wb_pkg;

    // Default number of interrupt sources
    localparam int N_INT_DEF = 9;

    // Register byte addresses
    localparam logic [7:0] ADR_CONFIG   = 8'h00;
    localparam logic [7:0] ADR_INT_PEND = 8'h08;
    localparam logic [7:0] ADR_INT_STAT = 8'h0C;
    localparam logic [7:0] ADR_INT_MASK = 8'h10;
    localparam logic [7:0] ADR_TX_CNT   = 8'h20;
    localparam logic [7:0] ADR_RX_CNT   = 8'h24;

    // Interrupt source bit positions
    localparam int INT_FRAG_ERR     = 0;
    localparam int INT_CRC_ERR      = 1;
    localparam int INT_PAUSE        = 2;
    localparam int INT_LOCAL_FAULT  = 3;
    localparam int INT_REMOTE_FAULT = 4;
    localparam int INT_RXF_OVF      = 5;
    localparam int INT_RXF_UNF      = 6;
    localparam int INT_TXF_OVF      = 7;
    localparam int INT_TXF_UNF      = 8;

    typedef logic [N_INT_DEF-1:0] int_vec_t;

    // Word index of a byte address; the two low bits are ignored
    function automatic logic [5:0] reg_idx(input logic [7:0] adr);
        return adr[7:2];
    endfunction

endpackage

// File: rtl/xge_sat_cnt.sv
// Saturating event counter with clear; an increment on the clear edge leaves 1.
module xge_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count pulses, hold at all-ones, clear on request (increment survives clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/xge_wb_regs.sv
// Wishbone classic slave register file for the 10GE MAC: configuration,
// interrupt pending/mask/status and frame statistics counters.
module xge_wb_regs
    import xge_wb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int N_INT     = N_INT_DEF,
    parameter bit TX_EN_RST = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_int_o,
    input  logic [N_INT-1:0]  int_evt_i,
    input  logic [N_INT-1:0]  int_lvl_i,
    input  logic              tx_frame_i,
    input  logic              rx_frame_i,
    output logic              cfg_tx_enable_o
);

    logic              ack_r;
    logic [DATA_W-1:0] dat_r;
    logic              int_r;
    logic              cfg_tx_en_r;
    logic [N_INT-1:0]  pend_r;
    logic [N_INT-1:0]  mask_r;

    logic              acc_s;
    logic              wr_s;
    logic              rd_s;
    logic              hit_cfg_s;
    logic              hit_pend_s;
    logic              hit_mask_s;
    logic              hit_tx_s;
    logic              hit_rx_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [31:0]       tx_cnt_s;
    logic [31:0]       rx_cnt_s;
    logic              clr_pend_s;
    logic              clr_tx_s;
    logic              clr_rx_s;
    logic              bus_unused_s;

    // A new access is accepted only when no acknowledge is outstanding
    assign acc_s = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s  = acc_s & wb_we_i;
    assign rd_s  = acc_s & ~wb_we_i;

    // Address bits outside [7:2] and write data above the widest field are don't-care
    assign bus_unused_s = ^{wb_adr_i, wb_dat_i};

    // Address decode and read-data multiplexer
    always_comb begin
        hit_cfg_s  = 1'b0;
        hit_pend_s = 1'b0;
        hit_mask_s = 1'b0;
        hit_tx_s   = 1'b0;
        hit_rx_s   = 1'b0;
        rd_data_s  = {DATA_W{1'b0}};
        case (reg_idx(wb_adr_i[7:0]))
            reg_idx(ADR_CONFIG): begin
                hit_cfg_s = 1'b1;
                rd_data_s = {{(DATA_W-1){1'b0}}, cfg_tx_en_r};
            end
            reg_idx(ADR_INT_PEND): begin
                hit_pend_s = 1'b1;
                rd_data_s  = {{(DATA_W-N_INT){1'b0}}, pend_r};
            end
            reg_idx(ADR_INT_STAT): begin
                rd_data_s = {{(DATA_W-N_INT){1'b0}}, int_lvl_i};
            end
            reg_idx(ADR_INT_MASK): begin
                hit_mask_s = 1'b1;
                rd_data_s  = {{(DATA_W-N_INT){1'b0}}, mask_r};
            end
            reg_idx(ADR_TX_CNT): begin
                hit_tx_s  = 1'b1;
                rd_data_s = tx_cnt_s;
            end
            reg_idx(ADR_RX_CNT): begin
                hit_rx_s  = 1'b1;
                rd_data_s = rx_cnt_s;
            end
            default: begin
                rd_data_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Clear-on-read strobes only fire for reads, never for writes
    assign clr_pend_s = rd_s & hit_pend_s;
    assign clr_tx_s   = rd_s & hit_tx_s;
    assign clr_rx_s   = rd_s & hit_rx_s;

    // Single-cycle acknowledge and registered read data (zero when not acking)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= {DATA_W{1'b0}};
        end else begin
            ack_r <= acc_s;
            dat_r <= rd_s ? rd_data_s : {DATA_W{1'b0}};
        end
    end

    // Writable configuration and interrupt mask
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cfg_tx_en_r <= TX_EN_RST;
            mask_r      <= {N_INT{1'b0}};
        end else begin
            if (wr_s && hit_cfg_s) begin
                cfg_tx_en_r <= wb_dat_i[0];
            end
            if (wr_s && hit_mask_s) begin
                mask_r <= wb_dat_i[N_INT-1:0];
            end
        end
    end

    // Pending bits: sticky on events, cleared by read, a coincident event wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pend_r <= {N_INT{1'b0}};
        end else if (clr_pend_s) begin
            pend_r <= int_evt_i;
        end else begin
            pend_r <= pend_r | int_evt_i;
        end
    end

    // Level interrupt to the host, one cycle behind pending/mask
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            int_r <= 1'b0;
        end else begin
            int_r <= |(pend_r & mask_r);
        end
    end

    xge_sat_cnt #(.WIDTH(32)) u_tx_cnt (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .inc   (tx_frame_i),
        .clr   (clr_tx_s),
        .count (tx_cnt_s)
    );

    xge_sat_cnt #(.WIDTH(32)) u_rx_cnt (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .inc   (rx_frame_i),
        .clr   (clr_rx_s),
        .count (rx_cnt_s)
    );

    assign wb_ack_o        = ack_r;
    assign wb_dat_o        = dat_r;
    assign wb_int_o        = int_r;
    assign cfg_tx_enable_o = cfg_tx_en_r;

endmodule
